// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: bundles the command, response and APB bus signals of apb_master_bridge.
// Signal suffixes are from the bridge's point of view.
//   cmd_*  : local controller command channel (valid/ready)
//   rsp_*  : response channel back to the controller (valid/ready)
//   busy_o : bridge is not idle
//   p*     : APB requester-side bus signals
// Modports: master = bridge side, slave = controller/peripheral environment side.
interface apb_master_bridge_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              cmd_valid_i;
   logic              cmd_ready_o;
   logic              cmd_write_i;
   logic [ADDR_W-1:0] cmd_addr_i;
   logic [DATA_W-1:0] cmd_wdata_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [DATA_W-1:0] rsp_rdata_o;
   logic              rsp_err_o;
   logic              rsp_timeout_o;
   logic              busy_o;
   logic              psel_o;
   logic              penable_o;
   logic              pwrite_o;
   logic [ADDR_W-1:0] paddr_o;
   logic [DATA_W-1:0] pwdata_o;
   logic [DATA_W-1:0] prdata_i;
   logic              pready_i;
   logic              pslverr_i;
   modport master (
      input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
             prdata_i, pready_i, pslverr_i,
      output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
             busy_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
   );
   modport slave (
      output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
             prdata_i, pready_i, pslverr_i,
      input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
             busy_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
   );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: APB requester turning single valid/ready commands into SETUP/ACCESS transfers.
// Ports:
//   pclk_i : clock, all logic on the rising edge
//   prst_i : asynchronous active-high reset
//   bus    : command, response and APB signals (apb_master_bridge_if.master)
// One transfer outstanding at a time; ACCESS is aborted after TIMEOUT_CYCLES
// cycles of pready_i low (0 disables the timeout).
module apb_master_bridge #(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                pclk_i,
   input  logic                prst_i,
   apb_master_bridge_if.master bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
   localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
   state_t            state_q;
   logic [15:0]       wait_q;
   logic              cmd_ready_q;
   logic              psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [DATA_W-1:0] pwdata_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;
   logic              rsp_timeout_q;
   always_ff @(posedge pclk_i or posedge prst_i) begin
      if (prst_i) begin
         state_q       <= IDLE;
         wait_q        <= '0;
         cmd_ready_q   <= 1'b1;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.cmd_valid_i) begin
               state_q     <= SETUP;
               cmd_ready_q <= 1'b0;
               psel_q      <= 1'b1;
               pwrite_q    <= bus.cmd_write_i;
               paddr_q     <= bus.cmd_addr_i;
               pwdata_q    <= bus.cmd_wdata_i;
               wait_q      <= '0;
            end
            SETUP: begin
               state_q   <= ACCESS;
               penable_q <= 1'b1;
            end
            ACCESS: if (bus.pready_i) begin
               state_q       <= RESP;
               psel_q        <= 1'b0;
               penable_q     <= 1'b0;
               rsp_valid_q   <= 1'b1;
               rsp_err_q     <= bus.pslverr_i;
               rsp_timeout_q <= 1'b0;
               rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata_i;
            end else if (TO_EN && wait_q == WAIT_LAST) begin
               // wait_q == TIMEOUT_CYCLES-1 here means this is the last permitted ACCESS cycle
               state_q       <= RESP;
               psel_q        <= 1'b0;
               penable_q     <= 1'b0;
               rsp_valid_q   <= 1'b1;
               rsp_err_q     <= 1'b1;
               rsp_timeout_q <= 1'b1;
               rsp_rdata_q   <= '0;
            end else begin
               wait_q <= wait_q + 16'd1;
            end
            RESP: if (bus.rsp_ready_i) begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
               cmd_ready_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.cmd_ready_o   = cmd_ready_q;
   assign bus.busy_o        = (state_q != IDLE);
   assign bus.psel_o        = psel_q;
   assign bus.penable_o     = penable_q;
   assign bus.pwrite_o      = pwrite_q;
   assign bus.paddr_o       = paddr_q;
   assign bus.pwdata_o      = pwdata_q;
   assign bus.rsp_valid_o   = rsp_valid_q;
   assign bus.rsp_rdata_o   = rsp_rdata_q;
   assign bus.rsp_err_o     = rsp_err_q;
   assign bus.rsp_timeout_o = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed and randomized transfers checked against a transaction-level model.
module tb_apb_master_bridge;
   localparam int TO = 16;
   logic pclk = 1'b0;
   logic prst = 1'b1;
   int checks = 0;
   int errors = 0;
   always #5 pclk = ~pclk;
   apb_master_bridge_if #(.ADDR_W(8), .DATA_W(8)) bus ();
   apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
      .pclk_i(pclk),
      .prst_i(prst),
      .bus   (bus)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // One complete transfer; the slave raises pready_i after `waits` low ACCESS cycles,
   // and the controller keeps rsp_ready_i low for `hold` response cycles.
   task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                       input logic [7:0] rdata, input int waits, input logic slverr, input int hold);
      int acc;
      int exp_acc;
      logic exp_to;
      logic exp_err;
      logic [7:0] exp_rd;
      exp_to  = (waits >= TO);
      exp_acc = exp_to ? TO : waits + 1;
      exp_rd  = (exp_to || wr) ? 8'h00 : rdata;
      exp_err = exp_to || slverr;
      chk("idle_cmd_ready", bus.cmd_ready_o, 1);
      chk("idle_busy", bus.busy_o, 0);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_write_i = wr;
      bus.cmd_addr_i  = addr;
      bus.cmd_wdata_i = wdata;
      @(posedge pclk); #1;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_write_i = 1'($urandom);
      bus.cmd_addr_i  = 8'($urandom);
      bus.cmd_wdata_i = 8'($urandom);
      chk("setup_psel", bus.psel_o, 1);
      chk("setup_penable", bus.penable_o, 0);
      chk("setup_paddr", bus.paddr_o, addr);
      chk("setup_pwrite", bus.pwrite_o, wr);
      chk("setup_pwdata", bus.pwdata_o, wdata);
      chk("setup_cmd_ready", bus.cmd_ready_o, 0);
      chk("setup_busy", bus.busy_o, 1);
      bus.pready_i  = 1'b1;
      bus.pslverr_i = 1'b1;
      bus.prdata_i  = 8'($urandom);
      @(posedge pclk); #1;
      acc = 0;
      while (bus.psel_o && bus.penable_o && acc < 100) begin
         chk("access_paddr", bus.paddr_o, addr);
         chk("access_pwrite", bus.pwrite_o, wr);
         chk("access_pwdata", bus.pwdata_o, wdata);
         bus.pready_i  = (acc == waits);
         bus.pslverr_i = (acc == waits) ? slverr : 1'($urandom);
         bus.prdata_i  = (acc == waits) ? rdata : 8'($urandom);
         acc++;
         @(posedge pclk); #1;
      end
      bus.pready_i  = 1'b0;
      bus.pslverr_i = 1'b0;
      chk("access_cycles", acc, exp_acc);
      for (int h = 0; h <= hold; h++) begin
         chk("rsp_valid", bus.rsp_valid_o, 1);
         chk("rsp_rdata", bus.rsp_rdata_o, exp_rd);
         chk("rsp_err", bus.rsp_err_o, exp_err);
         chk("rsp_timeout", bus.rsp_timeout_o, exp_to);
         chk("rsp_cmd_ready", bus.cmd_ready_o, 0);
         chk("rsp_psel", bus.psel_o, 0);
         chk("rsp_penable", bus.penable_o, 0);
         chk("rsp_paddr_held", bus.paddr_o, addr);
         if (h == hold) begin
            bus.rsp_ready_i = 1'b1;
            bus.cmd_valid_i = 1'b0;
         end else begin
            bus.cmd_valid_i = 1'($urandom);
            bus.cmd_addr_i  = 8'($urandom);
         end
         @(posedge pclk); #1;
      end
      bus.rsp_ready_i = 1'b0;
      chk("post_rsp_valid", bus.rsp_valid_o, 0);
      chk("post_cmd_ready", bus.cmd_ready_o, 1);
      chk("post_busy", bus.busy_o, 0);
   endtask
   initial begin
      logic wr;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_write_i = 1'b0;
      bus.cmd_addr_i  = 8'h00;
      bus.cmd_wdata_i = 8'h00;
      bus.rsp_ready_i = 1'b0;
      bus.prdata_i    = 8'h00;
      bus.pready_i    = 1'b0;
      bus.pslverr_i   = 1'b0;
      repeat (2) @(posedge pclk);
      #1;
      chk("reset_cmd_ready", bus.cmd_ready_o, 1);
      chk("reset_psel", bus.psel_o, 0);
      chk("reset_penable", bus.penable_o, 0);
      chk("reset_pwrite", bus.pwrite_o, 0);
      chk("reset_paddr", bus.paddr_o, 0);
      chk("reset_pwdata", bus.pwdata_o, 0);
      chk("reset_rsp_valid", bus.rsp_valid_o, 0);
      chk("reset_rsp_rdata", bus.rsp_rdata_o, 0);
      chk("reset_rsp_err", bus.rsp_err_o, 0);
      chk("reset_rsp_timeout", bus.rsp_timeout_o, 0);
      chk("reset_busy", bus.busy_o, 0);
      prst = 1'b0;
      @(posedge pclk); #1;
      xfer(1'b1, 8'h00, 8'h40, 8'h00, 0, 1'b0, 0);
      xfer(1'b0, 8'h00, 8'h00, 8'h5A, 3, 1'b0, 0);
      xfer(1'b0, 8'h10, 8'h00, 8'h77, 1000, 1'b0, 0);
      xfer(1'b0, 8'h21, 8'h00, 8'hC3, 0, 1'b1, 0);
      xfer(1'b1, 8'h05, 8'h99, 8'h3C, 15, 1'b0, 0);
      xfer(1'b1, 8'h06, 8'hAA, 8'h55, 16, 1'b1, 1);
      xfer(1'b0, 8'h44, 8'h00, 8'h12, 2, 1'b0, 5);
      for (int i = 0; i < 30; i++) begin
         wr = 1'($urandom);
         xfer(wr, 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 20)),
              1'($urandom), int'($urandom_range(0, 3)));
      end
      bus.cmd_valid_i = 1'b1;
      bus.cmd_write_i = 1'b0;
      bus.cmd_addr_i  = 8'h33;
      @(posedge pclk); #1;
      bus.cmd_valid_i = 1'b0;
      @(posedge pclk); #1;
      chk("prerst_penable", bus.penable_o, 1);
      @(posedge pclk); #2;
      prst = 1'b1;
      #1;
      chk("rst_psel", bus.psel_o, 0);
      chk("rst_penable", bus.penable_o, 0);
      chk("rst_cmd_ready", bus.cmd_ready_o, 1);
      chk("rst_rsp_valid", bus.rsp_valid_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      #2;
      prst = 1'b0;
      bus.pready_i = 1'b1;
      repeat (3) begin
         @(posedge pclk); #1;
         chk("rst_no_rsp", bus.rsp_valid_o, 0);
      end
      bus.pready_i = 1'b0;
      xfer(1'b0, 8'h33, 8'h00, 8'hE7, 1, 1'b0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
